// File: rtl/control_unit_pkg.sv
// Shared opcodes, FSM states and decoded control bundle
// for the RV64I multicycle control unit.
package control_unit_pkg;

  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM_W = 7'b0011011;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_W     = 7'b0111011;

  localparam logic [1:0] WR_ALU = 2'b00;
  localparam logic [1:0] WR_MEM = 2'b01;
  localparam logic [1:0] WR_PC4 = 2'b10;
  localparam logic [1:0] WR_IMM = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FETCH_WAIT,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK,
    HALT
  } state_t;

  typedef struct packed {
    logic       alua_src;
    logic       alub_src;
    logic       aluy_src;
    logic [2:0] alu_src;
    logic       carry_in;
    logic       arithmetic;
    logic       alupc_src;
    logic       jump;
    logic       branch;
    logic       load;
    logic       store;
    logic [2:0] funct3;
    logic [1:0] write_register_src;
  } ctrl_t;

  function automatic logic [63:0] store_mask(
    input logic [1:0] size
  );
    unique case (size)
      2'd0:    store_mask = 64'h01;
      2'd1:    store_mask = 64'h03;
      2'd2:    store_mask = 64'h0f;
      default: store_mask = 64'hff;
    endcase
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational instruction decoder: maps opcode/funct
// fields to the selector bundle registered by the FSM.
module control_decoder
  import control_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl,
  output logic       illegal
);

  logic reg_op;
  logic word_op;
  logic alu_op;
  logic sub_op;
  logic sra_op;
  logic slt_op;
  logic unused_funct7;

  assign reg_op  = (opcode == OP) || (opcode == OP_W);
  assign word_op = (opcode == OP_IMM_W) || (opcode == OP_W);
  assign alu_op  = reg_op || (opcode == OP_IMM)
                || (opcode == OP_IMM_W);
  assign sub_op  = reg_op && (funct3 == 3'b000) && funct7[5];
  assign sra_op  = (funct3 == 3'b101) && funct7[5];
  assign slt_op  = (funct3 == 3'b010) || (funct3 == 3'b011);
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    ctrl = '0;
    illegal = 1'b0;
    ctrl.funct3 = funct3;
    unique case (1'b1)
      (opcode == LUI): ctrl.write_register_src = WR_IMM;
      (opcode == AUIPC): begin
        ctrl.alua_src = 1'b1;
        ctrl.alub_src = 1'b1;
      end
      (opcode == JAL): begin
        ctrl.jump = 1'b1;
        ctrl.write_register_src = WR_PC4;
      end
      (opcode == JALR): begin
        ctrl.jump = 1'b1;
        ctrl.alupc_src = 1'b1;
        ctrl.write_register_src = WR_PC4;
      end
      (opcode == BRANCH): begin
        ctrl.branch = 1'b1;
        ctrl.carry_in = 1'b1;
        illegal = (funct3[2:1] == 2'b01);
      end
      (opcode == LOAD): begin
        ctrl.load = 1'b1;
        ctrl.alub_src = 1'b1;
        ctrl.write_register_src = WR_MEM;
      end
      (opcode == STORE): begin
        ctrl.store = 1'b1;
        ctrl.alub_src = 1'b1;
      end
      alu_op: begin
        ctrl.alu_src = funct3;
        ctrl.alub_src = !reg_op;
        ctrl.aluy_src = word_op;
        ctrl.arithmetic = sra_op || sub_op;
        ctrl.carry_in = sub_op || slt_op;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FSM sequencing fetch, decode, execute and
// memory phases and driving all Dataflow controls.
module multicycle_control_unit
  import control_unit_pkg::*;
#(
  parameter int BYTE_NUM = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                zero,
  input  logic                negative,
  input  logic                carry_out,
  input  logic                overflow,
  input  logic                instruction_mem_busy,
  input  logic                data_mem_busy,
  output logic                instruction_mem_enable,
  output logic                data_mem_enable,
  output logic [BYTE_NUM-1:0] data_mem_byte_write_enable,
  output logic                alua_src,
  output logic                alub_src,
  output logic                aluy_src,
  output logic [2:0]          alu_src,
  output logic                carry_in,
  output logic                arithmetic,
  output logic                alupc_src,
  output logic                pc_src,
  output logic                pc_enable,
  output logic [2:0]          read_data_src,
  output logic [1:0]          write_register_src,
  output logic                write_register_enable,
  output logic                illegal_instruction
);

  state_t      state;
  state_t      next_state;
  ctrl_t       ctrl;
  ctrl_t       ctrl_q;
  logic        illegal;
  logic        taken;
  logic [63:0] mask;
  logic        unused_mask;

  control_decoder u_decoder (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .ctrl    (ctrl),
    .illegal (illegal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      ctrl_q <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE) ctrl_q <= ctrl;
    end
  end

  assign mask = store_mask(ctrl_q.funct3[1:0]);
  assign unused_mask = ^mask;

  // Flags come from rs1 + ~rs2 + 1, so carry means rs1 >= rs2
  always_comb begin
    case (ctrl_q.funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = negative ^ overflow;
      3'b101:  taken = !(negative ^ overflow);
      3'b110:  taken = !carry_out;
      3'b111:  taken = carry_out;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    instruction_mem_enable = 1'b0;
    data_mem_enable = 1'b0;
    data_mem_byte_write_enable = '0;
    pc_src = 1'b0;
    pc_enable = 1'b0;
    write_register_enable = 1'b0;
    illegal_instruction = 1'b0;
    alua_src = ctrl_q.alua_src;
    alub_src = ctrl_q.alub_src;
    aluy_src = ctrl_q.aluy_src;
    alu_src = ctrl_q.alu_src;
    carry_in = ctrl_q.carry_in;
    arithmetic = ctrl_q.arithmetic;
    alupc_src = ctrl_q.alupc_src;
    read_data_src = ctrl_q.load ? ctrl_q.funct3 : 3'b000;
    write_register_src = ctrl_q.write_register_src;
    unique case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        instruction_mem_enable = 1'b1;
        next_state = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        instruction_mem_enable = 1'b1;
        if (!instruction_mem_busy) next_state = DECODE;
      end
      DECODE: begin
        if (illegal) next_state = HALT;
        else if (ctrl.load || ctrl.store) next_state = MEMORY;
        else next_state = EXECUTE;
      end
      EXECUTE: begin
        pc_enable = 1'b1;
        write_register_enable = !ctrl_q.branch;
        pc_src = ctrl_q.branch ? taken : ctrl_q.jump;
        next_state = FETCH;
      end
      MEMORY: begin
        data_mem_enable = 1'b1;
        if (ctrl_q.store)
          data_mem_byte_write_enable = mask[BYTE_NUM-1:0];
        if (!data_mem_busy) next_state = WRITEBACK;
      end
      WRITEBACK: begin
        pc_enable = 1'b1;
        write_register_enable = ctrl_q.load;
        next_state = FETCH;
      end
      HALT: illegal_instruction = 1'b1;
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: random and directed instructions
// compared against a spec-level reference model.
module tb_multicycle_control_unit;

  localparam logic [6:0] C_LUI   = 7'b0110111;
  localparam logic [6:0] C_AUIPC = 7'b0010111;
  localparam logic [6:0] C_JAL   = 7'b1101111;
  localparam logic [6:0] C_JALR  = 7'b1100111;
  localparam logic [6:0] C_BR    = 7'b1100011;
  localparam logic [6:0] C_LD    = 7'b0000011;
  localparam logic [6:0] C_ST    = 7'b0100011;
  localparam logic [6:0] C_OPI   = 7'b0010011;
  localparam logic [6:0] C_OPIW  = 7'b0011011;
  localparam logic [6:0] C_OP    = 7'b0110011;
  localparam logic [6:0] C_OPW   = 7'b0111011;

  typedef struct packed {
    logic [1:0] wr;
    logic [2:0] alu;
    logic       arith;
    logic       cin;
    logic       aluy;
    logic       alua;
    logic       alub;
    logic       alupc;
    logic [2:0] rds;
  } sel_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       zero = 1'b0;
  logic       negative = 1'b0;
  logic       carry_out = 1'b0;
  logic       overflow = 1'b0;
  logic       instruction_mem_busy = 1'b0;
  logic       data_mem_busy = 1'b0;
  logic       instruction_mem_enable;
  logic       data_mem_enable;
  logic [7:0] data_mem_byte_write_enable;
  logic       alua_src;
  logic       alub_src;
  logic       aluy_src;
  logic [2:0] alu_src;
  logic       carry_in;
  logic       arithmetic;
  logic       alupc_src;
  logic       pc_src;
  logic       pc_enable;
  logic [2:0] read_data_src;
  logic [1:0] write_register_src;
  logic       write_register_enable;
  logic       illegal_instruction;

  int errors = 0;
  int checks = 0;

  multicycle_control_unit #(.BYTE_NUM(8)) dut (
    .clock                      (clock),
    .reset                      (reset),
    .opcode                     (opcode),
    .funct3                     (funct3),
    .funct7                     (funct7),
    .zero                       (zero),
    .negative                   (negative),
    .carry_out                  (carry_out),
    .overflow                   (overflow),
    .instruction_mem_busy       (instruction_mem_busy),
    .data_mem_busy              (data_mem_busy),
    .instruction_mem_enable     (instruction_mem_enable),
    .data_mem_enable            (data_mem_enable),
    .data_mem_byte_write_enable (data_mem_byte_write_enable),
    .alua_src                   (alua_src),
    .alub_src                   (alub_src),
    .aluy_src                   (aluy_src),
    .alu_src                    (alu_src),
    .carry_in                   (carry_in),
    .arithmetic                 (arithmetic),
    .alupc_src                  (alupc_src),
    .pc_src                     (pc_src),
    .pc_enable                  (pc_enable),
    .read_data_src              (read_data_src),
    .write_register_src         (write_register_src),
    .write_register_enable      (write_register_enable),
    .illegal_instruction        (illegal_instruction)
  );

  always #5 clock = ~clock;

  function automatic logic [27:0] all_out();
    return {instruction_mem_enable, data_mem_enable,
            data_mem_byte_write_enable, alua_src, alub_src,
            aluy_src, alu_src, carry_in, arithmetic,
            alupc_src, pc_src, pc_enable, read_data_src,
            write_register_src, write_register_enable,
            illegal_instruction};
  endfunction

  function automatic sel_t model_sel(
    input logic [6:0] op, input logic [2:0] f3,
    input logic [6:0] f7
  );
    sel_t s;
    bit   r_type;
    bit   alu_cls;
    s = '0;
    r_type  = (op == C_OP) || (op == C_OPW);
    alu_cls = r_type || (op == C_OPI) || (op == C_OPIW);
    if (op == C_LUI) s.wr = 2'b11;
    if (op == C_JAL || op == C_JALR) s.wr = 2'b10;
    if (op == C_JALR) s.alupc = 1'b1;
    if (op == C_AUIPC) begin
      s.alua = 1'b1;
      s.alub = 1'b1;
    end
    if (op == C_BR) s.cin = 1'b1;
    if (op == C_LD) begin
      s.wr = 2'b01;
      s.rds = f3;
      s.alub = 1'b1;
    end
    if (op == C_ST) s.alub = 1'b1;
    if (alu_cls) begin
      s.alu = f3;
      s.alub = !r_type;
      s.aluy = (op == C_OPIW) || (op == C_OPW);
      s.arith = f7[5] && (f3 == 3'd5 || (r_type && f3 == 3'd0));
      s.cin = (r_type && f3 == 3'd0 && f7[5])
           || f3 == 3'd2 || f3 == 3'd3;
    end
    return s;
  endfunction

  function automatic logic br_taken(
    input logic [2:0] f3, input logic [63:0] a,
    input logic [63:0] b
  );
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_flags(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] d;
    d = {1'b0, a} + {1'b0, ~b} + 65'd1;
    zero      = (d[63:0] == 64'd0);
    negative  = d[63];
    carry_out = d[64];
    overflow  = (a[63] != b[63]) && (d[63] != a[63]);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    instruction_mem_busy = 1'b0;
    data_mem_busy = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_instr(
    input string name, input logic [6:0] op,
    input logic [2:0] f3, input logic [6:0] f7,
    input logic [63:0] a, input logic [63:0] b,
    input int ibusy, input int dbusy
  );
    sel_t s_exp;
    sel_t s_got;
    logic pc_exp;
    logic pc_got;
    logic [7:0] bwe_exp;
    bit   is_mem;
    int   wre_exp;
    int   imem_n = 0;
    int   dmem_n = 0;
    int   pc_n = 0;
    int   wre_n = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   done = 0;
    s_got = '0;
    pc_got = 1'b0;
    s_exp = model_sel(op, f3, f7);
    is_mem = (op == C_LD) || (op == C_ST);
    bwe_exp = (op == C_ST) ? 8'((9'd1 << (1 << f3[1:0])) - 9'd1) : 8'd0;
    pc_exp = (op == C_BR) ? br_taken(f3, a, b)
           : (op == C_JAL || op == C_JALR);
    wre_exp = (op == C_BR || op == C_ST) ? 0 : 1;
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    set_flags(a, b);
    while (!done && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (instruction_mem_enable) imem_n++;
      instruction_mem_busy = (imem_n <= ibusy + 1);
      if (data_mem_enable) begin
        dmem_n++;
        if (data_mem_byte_write_enable !== bwe_exp || alub_src !== 1'b1
            || alu_src !== 3'd0 || pc_enable || write_register_enable)
          bad++;
      end else if (data_mem_byte_write_enable !== 8'd0) bad++;
      data_mem_busy = (dmem_n <= dbusy);
      if (pc_enable && instruction_mem_enable) bad++;
      if (write_register_enable && !pc_enable) bad++;
      if (illegal_instruction) bad++;
      if (pc_enable) begin
        pc_n++;
        if (write_register_enable) wre_n++;
        s_got = {write_register_src, alu_src, arithmetic, carry_in,
                 aluy_src, alua_src, alub_src, alupc_src, read_data_src};
        pc_got = pc_src;
        done = 1;
      end
    end
    instruction_mem_busy = 1'b0;
    data_mem_busy = 1'b0;
    checks++;
    if (pc_n !== 1) begin
      errors++;
      $display("FAIL %s pc_pulses got=%0d exp=1", name, pc_n);
    end
    checks++;
    if (imem_n !== ibusy + 2) begin
      errors++;
      $display("FAIL %s fetch_cycles got=%0d exp=%0d", name, imem_n, ibusy + 2);
    end
    checks++;
    if (dmem_n !== (is_mem ? dbusy + 1 : 0)) begin
      errors++;
      $display("FAIL %s mem_cycles got=%0d exp=%0d", name, dmem_n,
               is_mem ? dbusy + 1 : 0);
    end
    checks++;
    if (wre_n !== wre_exp) begin
      errors++;
      $display("FAIL %s wre_pulses got=%0d exp=%0d", name, wre_n, wre_exp);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s protocol_violations got=%0d exp=0", name, bad);
    end
    checks++;
    if (s_got !== s_exp) begin
      errors++;
      $display("FAIL %s selectors got=%h exp=%h", name, s_got, s_exp);
    end
    checks++;
    if (pc_got !== pc_exp) begin
      errors++;
      $display("FAIL %s pc_src got=%b exp=%b", name, pc_got, pc_exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (all_out() !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", all_out());
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (instruction_mem_enable !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_fetch got=%b exp=1", instruction_mem_enable);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_wait();
    opcode = C_OP;
    funct3 = 3'd0;
    funct7 = 7'd0;
    instruction_mem_busy = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if (instruction_mem_enable !== 1'b1) begin
      errors++;
      $display("FAIL wait_fetch_enable got=%b exp=1", instruction_mem_enable);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (all_out() !== 28'd0) begin
      errors++;
      $display("FAIL wait_reset_outputs got=%h exp=0", all_out());
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (instruction_mem_enable !== 1'b1) begin
      errors++;
      $display("FAIL wait_reset_refetch got=%b exp=1", instruction_mem_enable);
    end
    do_reset();
  endtask

  task automatic test_halt(input string name, input logic [6:0] op,
                           input logic [2:0] f3);
    int cyc = 0;
    int bad = 0;
    opcode = op;
    funct3 = f3;
    funct7 = 7'd0;
    while (!illegal_instruction && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (pc_enable || write_register_enable || data_mem_enable) bad++;
    end
    checks++;
    if (illegal_instruction !== 1'b1) begin
      errors++;
      $display("FAIL %s halt_entered got=%b exp=1", name, illegal_instruction);
    end
    repeat (20) begin
      @(negedge clock);
      if (illegal_instruction !== 1'b1 || instruction_mem_enable
          || data_mem_enable || pc_enable || write_register_enable
          || data_mem_byte_write_enable !== 8'd0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s halt_hold got=%0d exp=0", name, bad);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (all_out() !== 28'd0) begin
      errors++;
      $display("FAIL %s halt_cleared got=%h exp=0", name, all_out());
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_instr("add", C_OP, 3'd0, 7'h00, 64'd5, 64'd3, 3, 0);
    run_instr("sub", C_OP, 3'd0, 7'h20, 64'd5, 64'd3, 0, 0);
    run_instr("addi_f7", C_OPI, 3'd0, 7'h20, 64'd1, 64'd1, 1, 0);
    run_instr("sraw", C_OPW, 3'd5, 7'h20, 64'd1, 64'd2, 0, 0);
    run_instr("sd", C_ST, 3'd3, 7'h00, 64'd0, 64'd0, 0, 5);
    run_instr("sb", C_ST, 3'd0, 7'h00, 64'd0, 64'd0, 2, 0);
    run_instr("lhu", C_LD, 3'd5, 7'h00, 64'd0, 64'd0, 0, 2);
    run_instr("bltu_c0", C_BR, 3'd6, 7'h00, 64'd1, 64'd9, 0, 0);
    run_instr("bltu_c1", C_BR, 3'd6, 7'h00, 64'd9, 64'd1, 0, 0);
    run_instr("jalr", C_JALR, 3'd0, 7'h00, 64'd0, 64'd0, 0, 0);
    run_instr("lui", C_LUI, 3'd2, 7'h00, 64'd0, 64'd0, 0, 0);
  endtask

  task automatic test_random();
    logic [6:0] opcs [11];
    logic [2:0] brs [6];
    logic [6:0] op;
    logic [2:0] f3;
    logic [63:0] a;
    logic [63:0] b;
    opcs = '{C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LD,
             C_ST, C_OPI, C_OPIW, C_OP, C_OPW};
    brs = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int i = 0; i < 40; i++) begin
      op = opcs[$urandom_range(0, 10)];
      f3 = 3'($urandom_range(0, 7));
      if (op == C_BR) f3 = brs[$urandom_range(0, 5)];
      if (op == C_LD) f3 = 3'($urandom_range(0, 6));
      if (op == C_ST) f3 = 3'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = a;
      run_instr("random", op, f3, 7'($urandom), a, b,
                $urandom_range(0, 4), $urandom_range(0, 4));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_wait();
    test_random();
    test_halt("op_zero", 7'd0, 3'd0);
    do_reset();
    test_halt("branch_f3_010", C_BR, 3'd2);
    do_reset();
    run_instr("after_halt", C_OP, 3'd0, 7'h00, 64'd1, 64'd1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
